// File: rtl/fetch_sched_if.sv
// Fetch-side bus of fetch_sched: IM port, redirect request and the decode handshake.
interface fetch_sched_if;
  logic [11:2] IM_Addr;
  logic [31:0] IM_Instr;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Valid_D;
  logic        Ready_D;
  logic [31:0] PC_D;
  logic [31:0] Instr_D;
  logic        Exc_D;
  logic        Halted;

  modport master (
    output IM_Addr, Valid_D, PC_D, Instr_D, Exc_D, Halted,
    input  IM_Instr, Redirect, RedirectPC, Ready_D
  );
  modport slave (
    input  IM_Addr, Valid_D, PC_D, Instr_D, Exc_D, Halted,
    output IM_Instr, Redirect, RedirectPC, Ready_D
  );
endinterface

// File: rtl/fetch_sched.sv
// Instruction-fetch scheduler: owns PC_F, drives the IM, buffers {PC,Instr,Exc} in a 2-entry queue.
// Define FETCH_ADEL_EN to push an AdEL error entry when fetch leaves the legal window.
module fetch_sched #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  fetch_sched_if.master bus
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } entry_t;

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  entry_t      fifo_q [2];
  logic [1:0]  cnt_q;
  logic        rd_q, wr_q;

  logic        legal, valid, pop, space, push_ok, push_err, push;
  entry_t      push_entry, head;
  logic [32:0] win_end;

  assign bus.IM_Addr = pc_q[11:2] - RESET_PC[11:2];

  // 33-bit compare so a window touching 2^32 cannot wrap
  assign win_end = {1'b0, RESET_PC} + 33'(IM_WORDS) * 33'd4;
  assign legal   = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} >= {1'b0, RESET_PC}) &&
                   ({1'b0, pc_q} < win_end);

  assign valid   = (cnt_q != 2'd0);
  assign pop     = valid & bus.Ready_D & ~bus.Redirect;
  assign space   = (cnt_q != 2'd2) | pop;
  assign push_ok = (state_q == RUN) & legal & space & ~bus.Redirect;
`ifdef FETCH_ADEL_EN
  assign push_err = (state_q == RUN) & ~legal & space & ~bus.Redirect;
`else
  assign push_err = 1'b0;
`endif
  assign push       = push_ok | push_err;
  assign push_entry = push_err ? entry_t'{pc: pc_q, instr: 32'h0, exc: 1'b1}
                               : entry_t'{pc: pc_q, instr: bus.IM_Instr, exc: 1'b0};

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: if (!legal) begin
`ifdef FETCH_ADEL_EN
        if (space) state_d = HALT;
`else
        state_d = HALT;
`endif
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
    if (bus.Redirect) state_d = RUN;
  end

  always_comb begin
    bus.Halted = (state_q == HALT);
  end

  always_comb begin
    pc_d = pc_q;
    if (bus.Redirect)  pc_d = bus.RedirectPC;
    else if (push_ok)  pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (bus.Redirect) begin
        cnt_q <= 2'd0;
        rd_q  <= 1'b0;
        wr_q  <= 1'b0;
      end else begin
        if (push) begin
          fifo_q[wr_q] <= push_entry;
          wr_q         <= ~wr_q;
        end
        if (pop) rd_q <= ~rd_q;
        cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign head        = fifo_q[rd_q];
  assign bus.Valid_D = valid;
  assign bus.PC_D    = valid ? head.pc    : 32'h0;
  assign bus.Instr_D = valid ? head.instr : 32'h0;
  assign bus.Exc_D   = valid & head.exc;
endmodule

// File: tb/tb_fetch_sched.sv
// Scoreboard bench for fetch_sched: directed test-plan scenarios, then random traffic.
module tb_fetch_sched;
  localparam logic [31:0] RP = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_sched_if bus ();
  fetch_sched #(.RESET_PC(RP), .IM_WORDS(1024)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] im [1024];
  assign bus.IM_Instr = im[bus.IM_Addr];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t        sb_q [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mpc;
  bit          mhalt;
  int          mcount;
  bit          started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_pc(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && ({1'b0, pc} >= {1'b0, RP}) && ({1'b0, pc} < {1'b0, RP} + 33'd4096);
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - RP;
    return off[11:2];
  endfunction

  // Reference model: PC, halt flag and occupancy; every fetched entry goes to the scoreboard
  always @(posedge clk) begin
    bit   mpop, mspace;
    exp_t e;
    started = 1'b1;
    if (reset) begin
      mpc = RP; mhalt = 1'b0; mcount = 0; sb_q.delete();
    end else if (bus.Redirect) begin
      mpc = bus.RedirectPC; mhalt = 1'b0; mcount = 0; sb_q.delete();
    end else begin
      mpop   = (mcount > 0) && bus.Ready_D;
      mspace = (mcount < 2) || mpop;
      if (mpop) mcount--;
      if (!mhalt) begin
        if (legal_pc(mpc)) begin
          if (mspace) begin
            e.pc = mpc; e.instr = im[widx(mpc)]; e.exc = 1'b0;
            sb_q.push_back(e); mcount++; mpc = mpc + 32'd4;
          end
        end else begin
`ifdef FETCH_ADEL_EN
          if (mspace) begin
            e.pc = mpc; e.instr = 32'h0; e.exc = 1'b1;
            sb_q.push_back(e); mcount++; mhalt = 1'b1;
          end
`else
          mhalt = 1'b1;
`endif
        end
      end
    end
  end

  // Monitor: compares the presented head against the scoreboard, pops on handshake
  always @(negedge clk) begin
    #2;
    if (started) begin
      chk("valid", 32'(bus.Valid_D), 32'(mcount != 0));
      chk("halted", 32'(bus.Halted), 32'(mhalt));
      chk("im_addr", 32'(bus.IM_Addr), 32'(widx(mpc)));
      if (bus.Valid_D) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL head: Valid_D=1 PC_D=%h but no entry expected (t=%0t)", bus.PC_D, $time);
        end else begin
          chk("pc_d", bus.PC_D, sb_q[0].pc);
          chk("instr_d", bus.Instr_D, sb_q[0].instr);
          chk("exc_d", 32'(bus.Exc_D), 32'(sb_q[0].exc));
          if (bus.Ready_D && !bus.Redirect && !reset) void'(sb_q.pop_front());
        end
      end else begin
        chk("pc_d_idle", bus.PC_D, 32'h0);
        chk("instr_d_idle", bus.Instr_D, 32'h0);
        chk("exc_d_idle", 32'(bus.Exc_D), 32'h0);
      end
    end
  end

  task automatic cyc(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    reset = r; bus.Ready_D = rdy; bus.Redirect = rd; bus.RedirectPC = rpc;
    @(posedge clk);
    #3;
  endtask

  initial begin
    logic [31:0] rpc;
    bus.Ready_D = 1'b0; bus.Redirect = 1'b0; bus.RedirectPC = 32'h0;
    for (int i = 0; i < 1024; i++) im[i] = $urandom;
    im[0] = 32'hAAAA_0000; im[1] = 32'hBBBB_0001; im[2] = 32'hCCCC_0002; im[3] = 32'hDDDD_0003;

    // reset, then streaming at full rate
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("rst_valid", 32'(bus.Valid_D), 0); chk("rst_halted", 32'(bus.Halted), 0);
    chk("rst_imaddr", 32'(bus.IM_Addr), 0); chk("rst_pc_d", bus.PC_D, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0);
      chk("stream_pc", bus.PC_D, RP + 32'(4 * i));
      chk("stream_instr", bus.Instr_D, im[i]);
    end

    // decode stall: queue fills, PC_F freezes at 0x3008
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    chk("stall_imaddr", 32'(bus.IM_Addr), 32'd2);
    chk("stall_head", bus.PC_D, 32'h3000);
    cyc(0, 1, 0, 0); chk("release1", bus.PC_D, 32'h3004);
    cyc(0, 1, 0, 0); chk("release2", bus.PC_D, 32'h3008);

    // redirect with a full queue
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h3100); chk("redir_bubble", 32'(bus.Valid_D), 0);
    cyc(0, 1, 0, 0);
    chk("redir_pc", bus.PC_D, 32'h3100); chk("redir_instr", bus.Instr_D, im[64]);

    // run off the end of the window
    cyc(0, 1, 1, 32'h3FF8);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("end_halted", 32'(bus.Halted), 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("end_drained", 32'(bus.Valid_D), 0);

    // misaligned redirect, then recovery
    cyc(0, 0, 1, 32'h3002); cyc(0, 0, 0, 0);
    chk("mis_halted", 32'(bus.Halted), 1);
`ifdef FETCH_ADEL_EN
    chk("mis_pc", bus.PC_D, 32'h3002); chk("mis_exc", 32'(bus.Exc_D), 1);
`endif
    cyc(0, 1, 1, 32'h3000); cyc(0, 1, 0, 0);
    chk("resume_halted", 32'(bus.Halted), 0); chk("resume_pc", bus.PC_D, 32'h3000);

    // reset beats a simultaneous redirect
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 32'h3100);
    chk("rr_valid", 32'(bus.Valid_D), 0); chk("rr_pc_d", bus.PC_D, 0);
    chk("rr_imaddr", 32'(bus.IM_Addr), 0); chk("rr_halted", 32'(bus.Halted), 0);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom % 8)
        0, 1, 2, 3, 4: rpc = RP + 32'(($urandom % 1024) * 4);
        5:             rpc = RP + 32'd4096 - 32'(4 * ($urandom % 4));
        6:             rpc = RP + 32'($urandom % 4096) | 32'h1;
        default:       rpc = $urandom;
      endcase
      cyc(($urandom % 200) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0, rpc);
    end
    cyc(0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sched.md
# fetch_sched

Instruction-fetch scheduler sitting between the PC and the combinational instruction memory (1024 words, word address PC[11:2]). It owns the fetch PC and drives the IM word address each cycle. It captures {PC, instruction} pairs into a 2-entry prefetch queue and hands them to the decode stage over a valid/ready handshake. Branch/jump redirects flush the queue, and out-of-range or misaligned fetch addresses stop fetching.

## Interface
- RESET_PC, 32'h0000_3000, fetch PC loaded on reset; base of the IM window.
- IM_WORDS, 1024, IM depth in words; legal window is [RESET_PC, RESET_PC + 4*IM_WORDS).
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- IM_Addr  out  [11:2]  IM word address, (PC_F - RESET_PC)[11:2], combinational from PC_F.
- IM_Instr  in  32  IM read data, combinational response to IM_Addr.
- Redirect  in  1  branch/jump/exception redirect request.
- RedirectPC  in  32  target PC, sampled when Redirect=1.
- Valid_D  out  1  queue head valid.
- Ready_D  in  1  decode accepts head (low = decode stall).
- PC_D  out  32  PC of queue head.
- Instr_D  out  32  instruction of queue head.
- Exc_D  out  1  head carries a fetch address error (AdEL).
- Halted  out  1  fetch is stopped in HALT.

## Operation
- State: PC_F (32), state ∈ {RUN, HALT}, 2-entry FIFO of {PC, Instr, Exc}, count (0..2), rd/wr pointers (1 bit each).
- Legal(PC_F) = PC_F[1:0]==0 and RESET_PC ≤ PC_F < RESET_PC+4*IM_WORDS, with 33-bit unsigned compare and no wrap.
- pop = Valid_D & Ready_D.
- push (RUN only) = Legal(PC_F) & (count<2 | pop); pushes {PC_F, IM_Instr, 0} and PC_F ← PC_F+4 (mod 2^32).
- RUN with !Legal(PC_F): state ← HALT; PC_F unchanged; no normal push (see Configuration).
- HALT: no pushes; the queue keeps draining via pop; Halted=1.
- Redirect (highest priority, any state):
  - FIFO flushed (count←0, pointers←0), pop and push suppressed that cycle.
  - PC_F ← RedirectPC, state ← RUN.
  - If RedirectPC is illegal, HALT is entered one cycle later by the normal RUN rule.
- Push and pop in the same cycle with count=2: allowed; count stays 2, ordering preserved.
- count update: count + push − pop.
- Valid_D = (count≠0). PC_D/Instr_D/Exc_D = head entry. When count=0, PC_D/Instr_D/Exc_D = 0.

## Timing
- Reset values: PC_F=RESET_PC, state=RUN, count=0, Valid_D=0, PC_D=0, Instr_D=0, Exc_D=0, Halted=0. IM_Addr=0.
- Fetch latency: instruction at PC_F is visible on Valid_D/Instr_D the cycle after the push edge; first valid the cycle after reset deasserts.
- Sustained throughput: 1 instruction/cycle while Ready_D=1.
- Ready_D low for N cycles: the queue fills in ≤2 cycles, then PC_F freezes; no instruction is lost or duplicated.
- Redirect asserted at edge k: Valid_D=0 during cycle k+1; the target instruction is valid at cycle k+2.
- Redirect while Valid_D & Ready_D: the head is not popped. Decode must squash it itself; the entry is discarded by the flush.
- Reset mid-operation overrides Redirect and all queue activity.

## Configuration
- FETCH_ADEL_EN defined: on the RUN→HALT transition, one entry {PC_F, 32'h0, 1} is pushed if space allows (count<2 | pop). Otherwise the transition waits in RUN until space is available. Exc_D reports it at the head.
- Not defined: no error entry; RUN→HALT is immediate, and Exc_D is constant 0.

## Test plan
- Reset, Ready_D=1, IM[0..3]=A,B,C,D: cycles 1..4 present PC_D=0x3000..0x300C with Instr_D=A..D, Valid_D=1 continuously.
- Ready_D=0 for 5 cycles after first valid: count saturates at 2, PC_F stops at 0x3008. On release, the sequence is 0x3000, 0x3004, 0x3008 with no gaps or duplicates.
- Redirect=1, RedirectPC=0x3100 while count=2: next cycle Valid_D=0; the following cycle PC_D=0x3100 with Instr_D=IM[64].
- Fetch to the last word 0x3FFC: after it is pushed, Halted=1. With FETCH_ADEL_EN, one entry PC_D=0x4000, Exc_D=1 follows; without it, no further Valid_D.
- RedirectPC=0x3002 (misaligned): HALT after one cycle. Exc_D=1 with PC_D=0x3002 under FETCH_ADEL_EN. A subsequent Redirect to 0x3000 resumes fetching.
- Reset asserted mid-stream with count=2 and Redirect=1 in the same cycle: next cycle all outputs are at reset values and PC_F=0x3000.
